// File: rtl/dmem_block_responder_pkg.sv
// Shared definitions for the block-granular memory responder.
//   stateT : FSM encoding (IDLE, BUSY, DONE)
//   opT    : latched operation kind (OP_READ, OP_WRITE)
//   DEF_*  : default widths and sizes used by the interface and the top
//   idxWidth(): array index width for a given depth (at least 1 bit)
package dmem_block_responder_pkg;

  localparam int DEF_ADDR_W     = 10;
  localparam int DEF_BLOCK_BITS = 256;
  localparam int DEF_DEPTH      = 1024;
  localparam int DEF_LATENCY    = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } stateT;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } opT;

  function automatic int idxWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dmem_block_responder_if.sv
// Cache <-> memory block handshake bundle.
//   master (cache side) : drives ren, wen, block_address, din
//                         observes read_ready, write_done, dout, busy, err_both
//   slave  (memory side): the mirror image
interface dmem_block_responder_if
  import dmem_block_responder_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int BLOCK_BITS = DEF_BLOCK_BITS
);

  logic                  ren;
  logic                  wen;
  logic [ADDR_W-1:0]     block_address;
  logic [BLOCK_BITS-1:0] din;
  logic                  read_ready;
  logic                  write_done;
  logic [BLOCK_BITS-1:0] dout;
  logic                  busy;
  logic                  err_both;

  modport master (
    output ren, wen, block_address, din,
    input  read_ready, write_done, dout, busy, err_both
  );

  modport slave (
    input  ren, wen, block_address, din,
    output read_ready, write_done, dout, busy, err_both
  );

endinterface

// File: rtl/dmem_block_responder_mem_block_array.sv
// DEPTH x BLOCK_BITS block store with a synchronous single-port interface.
//   clock : rising-edge clock
//   en    : access enable for this edge
//   we    : 1 = write wdata to idx, 0 = read idx into rdata
//   idx   : block index
//   wdata : write block data
//   rdata : registered read data, updated only by enabled reads
module mem_block_array
  import dmem_block_responder_pkg::*;
#(
  parameter int DEPTH      = DEF_DEPTH,
  parameter int BLOCK_BITS = DEF_BLOCK_BITS,
  parameter int IDX_W      = idxWidth(DEPTH)
) (
  input  logic                  clock,
  input  logic                  en,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [BLOCK_BITS-1:0] wdata,
  output logic [BLOCK_BITS-1:0] rdata
);

  logic [BLOCK_BITS-1:0] mem [DEPTH];

  // NOTE: no reset on the storage so it maps onto RAM macros; contents survive reset.
  always_ff @(posedge clock) begin
    if (en) begin
      // NOTE: non-blocking assignments for all clocked state avoid simulation races.
      if (we) mem[idx] <= wdata;
      else    rdata    <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_block_responder.sv
// Memory-side responder: accepts one block read or write at a time and
// completes it after a fixed latency with a one-cycle pulse.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of the block handshake (ren/wen/block_address/din in;
//           read_ready/write_done/dout/busy/err_both out)
module dmem_block_responder
  import dmem_block_responder_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int BLOCK_BITS = DEF_BLOCK_BITS,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int LATENCY    = DEF_LATENCY
) (
  input  logic                    clock,
  input  logic                    reset,
  dmem_block_responder_if.slave   bus
);

  localparam int IDX_W = idxWidth(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  stateT                 state;
  stateT                 stateNext;
  opT                    opQ;
  logic [IDX_W-1:0]      idxQ;
  logic [BLOCK_BITS-1:0] dinQ;
  logic [BLOCK_BITS-1:0] doutQ;
  logic [BLOCK_BITS-1:0] memRdata;
  logic [CNT_W-1:0]      cntQ;
  logic                  errBothQ;
  logic                  reqLine;
  logic                  accept;
  logic                  memEn;
  logic                  readDone;
  logic                  writeDone;

  // The request line that must stay high for the latched operation to survive.
  assign reqLine = (opQ == OP_WRITE) ? bus.wen : bus.ren;
  assign accept  = (state == IDLE) && (bus.ren || bus.wen);

  // Only the low address bits select a block; the rest wrap.
  if (ADDR_W > IDX_W) begin : gUnusedAddr
    logic unusedAddrBits;
    assign unusedAddrBits = ^bus.block_address[ADDR_W-1:IDX_W];
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output -- no latches.
    stateNext = state;
    memEn     = 1'b0;
    unique case (state)
      IDLE: if (accept) stateNext = BUSY;
      BUSY: begin
        // Abort has priority over completion: nothing is committed.
        if (!reqLine) begin
          stateNext = IDLE;
        end else if (cntQ == '0) begin
          stateNext = DONE;
          memEn     = 1'b1; // write commits, or read data lands during DONE
        end
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (reset) memEn = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      opQ      <= OP_READ;
      cntQ     <= '0;
      errBothQ <= 1'b0;
      doutQ    <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        opQ  <= bus.wen ? OP_WRITE : OP_READ; // write wins on a collision
        cntQ <= CNT_LOAD;
        if (bus.ren && bus.wen) errBothQ <= 1'b1;
      end else if ((state == BUSY) && (cntQ != '0)) begin
        cntQ <= cntQ - 1'b1;
      end
      if (readDone) doutQ <= memRdata;
    end
  end

  // Request payload is only consumed after acceptance, so it needs no reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      idxQ <= bus.block_address[IDX_W-1:0];
      dinQ <= bus.din;
    end
  end

  mem_block_array #(
    .DEPTH      (DEPTH),
    .BLOCK_BITS (BLOCK_BITS),
    .IDX_W      (IDX_W)
  ) uArray (
    .clock (clock),
    .en    (memEn),
    .we    (opQ == OP_WRITE),
    .idx   (idxQ),
    .wdata (dinQ),
    .rdata (memRdata)
  );

  // A reset arriving in DONE suppresses the completion pulse.
  assign readDone  = (state == DONE) && (opQ == OP_READ)  && !reset;
  assign writeDone = (state == DONE) && (opQ == OP_WRITE) && !reset;

  assign bus.read_ready = readDone;
  assign bus.write_done = writeDone;
  // Fresh array data is visible in the DONE cycle itself, then held.
  assign bus.dout       = readDone ? memRdata : doutQ;
  assign bus.busy       = (state != IDLE);
  assign bus.err_both   = errBothQ;

endmodule
